decode_stage: RTL and testbench

Parametrised, pipelined successor to the combinational instruction decoder of the 16-bit Harvard processor. It accepts fetched instruction words over a valid/ready handshake and splits each one into opcode class, register indices, memory addresses, an immediate and per-field use enables. It also flags illegal opcodes. Results are held in a 2-entry skid buffer, so the decode stage sustains one instruction per cycle with a registered `in_ready`. The block sits between instruction fetch and register read / execute.

---
 rtl/decode_pkg.sv | 36 +++
 rtl/decode_skid2.sv | 99 +++++++++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode map, class encoding,
// control-bit positions and the packed decoded-packet width.
package decode_pkg;

    localparam int unsigned OP_LDI       = 32'd0;
    localparam int unsigned OP_MOV       = 32'd1;
    localparam int unsigned OP_LD        = 32'd2;
    localparam int unsigned OP_ST        = 32'd3;
    localparam int unsigned OP_ALU_FIRST = 32'd4;
    localparam int unsigned OP_ALU_LAST  = 32'd16;

    typedef enum logic [2:0] {
        CLS_LDI     = 3'd0,
        CLS_MOV     = 3'd1,
        CLS_LD      = 3'd2,
        CLS_ST      = 3'd3,
        CLS_ALU     = 3'd4,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    localparam int CTL_W       = 32'd7;
    localparam int CTL_WR_DST2 = 32'd6;
    localparam int CTL_WR_DST1 = 32'd5;
    localparam int CTL_RD_SRC2 = 32'd4;
    localparam int CTL_RD_SRC1 = 32'd3;
    localparam int CTL_USE_IMM = 32'd2;
    localparam int CTL_MEM_RD  = 32'd1;
    localparam int CTL_MEM_WR  = 32'd0;

    // opcode + class + four regs + two addresses + imm + ctl + illegal flag
    function automatic int pkt_width(input int opc_w, input int reg_w,
                                     input int addr_w, input int imm_w);
        return opc_w + 3 + 4 * reg_w + 2 * addr_w + imm_w + CTL_W + 1;
    endfunction

endpackage

// File: rtl/decode_skid2.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// in_ready and out_valid are both flop outputs.
module decode_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e       state_r, state_nxt_s;
    logic [W-1:0] head_r, head_nxt_s;
    logic [W-1:0] tail_r, tail_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         push_s;
    logic         pop_s;

    assign push_s    = in_valid && in_ready_r;
    assign pop_s     = out_valid_r && out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = head_r;

    // Next occupancy and entry contents; flush overrides any push or pop.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        if (flush) begin
            state_nxt_s = S_EMPTY;
        end else begin
            case (state_r)
                S_EMPTY: begin
                    if (push_s) begin
                        state_nxt_s = S_ONE;
                        head_nxt_s  = din;
                    end else begin
                        state_nxt_s = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (push_s && pop_s) begin
                        state_nxt_s = S_ONE;
                        head_nxt_s  = din;
                    end else if (push_s) begin
                        state_nxt_s = S_FULL;
                        tail_nxt_s  = din;
                    end else if (pop_s) begin
                        state_nxt_s = S_EMPTY;
                    end else begin
                        state_nxt_s = S_ONE;
                    end
                end
                S_FULL: begin
                    if (pop_s) begin
                        state_nxt_s = S_ONE;
                        head_nxt_s  = tail_r;
                    end else begin
                        state_nxt_s = S_FULL;
                    end
                end
                default: begin
                    state_nxt_s = S_EMPTY;
                end
            endcase
        end
    end

    // State, entries and the registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_EMPTY;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            in_ready_r  <= (state_nxt_s != S_FULL);
            out_valid_r <= (state_nxt_s != S_EMPTY);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined instruction decode: combinational field/class decode at the input,
// results held in a two-entry skid buffer, plus a saturating illegal counter.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_W   = 5,
    parameter int ADDR_W  = 8,
    parameter int IMM_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [2:0]         out_class,
    output logic [REG_W-1:0]   rdst2,
    output logic [REG_W-1:0]   rdst1,
    output logic [REG_W-1:0]   rsrc2,
    output logic [REG_W-1:0]   rsrc1,
    output logic [ADDR_W-1:0]  src_addr,
    output logic [ADDR_W-1:0]  dst_addr,
    output logic [IMM_W-1:0]   imm,
    output logic [6:0]         ctl,
    output logic               illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);
    import decode_pkg::*;

    localparam int T     = INSTR_W - OPC_W;
    localparam int PKT_W = pkt_width(OPC_W, REG_W, ADDR_W, IMM_W);

    if ((OPC_W + 2 * REG_W > INSTR_W - 2 * REG_W) ||
        (IMM_W > INSTR_W - OPC_W - REG_W) ||
        (ADDR_W > INSTR_W - OPC_W - REG_W)) begin : g_bad_params
        $error("decode_stage: field widths do not fit the instruction word");
    end

    logic [OPC_W-1:0]  opcode_s;
    logic [31:0]       opc_ext_s;
    cls_e              cls_s;
    logic [REG_W-1:0]  rdst2_s, rdst1_s, rsrc2_s, rsrc1_s;
    logic [ADDR_W-1:0] src_addr_s, dst_addr_s;
    logic [IMM_W-1:0]  imm_s;
    logic [CTL_W-1:0]  ctl_s;
    logic              illegal_s;
    logic [PKT_W-1:0]  pkt_in_s, pkt_out_s;
    logic              accept_s;
    logic [CNT_W-1:0]  cnt_r;

    assign opcode_s  = instr[INSTR_W-1 -: OPC_W];
    assign opc_ext_s = 32'(opcode_s);

    // Field extraction by class; fields a class does not use stay zero.
    always_comb begin
        cls_s      = CLS_ILLEGAL;
        rdst2_s    = '0;
        rdst1_s    = '0;
        rsrc2_s    = '0;
        rsrc1_s    = '0;
        src_addr_s = '0;
        dst_addr_s = '0;
        imm_s      = '0;
        ctl_s      = '0;
        illegal_s  = 1'b0;
        if (opc_ext_s == OP_LDI) begin
            cls_s              = CLS_LDI;
            rdst2_s            = instr[T-1 -: REG_W];
            imm_s              = instr[IMM_W-1:0];
            ctl_s[CTL_WR_DST2] = 1'b1;
            ctl_s[CTL_USE_IMM] = 1'b1;
        end else if (opc_ext_s == OP_MOV) begin
            cls_s              = CLS_MOV;
            rdst2_s            = instr[T-1 -: REG_W];
            rsrc2_s            = instr[2*REG_W-1:REG_W];
            ctl_s[CTL_WR_DST2] = 1'b1;
            ctl_s[CTL_RD_SRC2] = 1'b1;
        end else if (opc_ext_s == OP_LD) begin
            cls_s              = CLS_LD;
            rdst2_s            = instr[T-1 -: REG_W];
            src_addr_s         = instr[ADDR_W-1:0];
            ctl_s[CTL_WR_DST2] = 1'b1;
            ctl_s[CTL_MEM_RD]  = 1'b1;
        end else if (opc_ext_s == OP_ST) begin
            cls_s              = CLS_ST;
            dst_addr_s         = instr[T-1 -: ADDR_W];
            rsrc2_s            = instr[2*REG_W-1:REG_W];
            ctl_s[CTL_RD_SRC2] = 1'b1;
            ctl_s[CTL_MEM_WR]  = 1'b1;
        end else if ((opc_ext_s >= OP_ALU_FIRST) && (opc_ext_s <= OP_ALU_LAST)) begin
            cls_s              = CLS_ALU;
            rdst2_s            = instr[T-1 -: REG_W];
            rdst1_s            = instr[T-REG_W-1 -: REG_W];
            rsrc2_s            = instr[2*REG_W-1:REG_W];
            rsrc1_s            = instr[REG_W-1:0];
            ctl_s[CTL_WR_DST2] = 1'b1;
            ctl_s[CTL_WR_DST1] = 1'b1;
            ctl_s[CTL_RD_SRC2] = 1'b1;
            ctl_s[CTL_RD_SRC1] = 1'b1;
        end else begin
            cls_s     = CLS_ILLEGAL;
            illegal_s = 1'b1;
        end
    end

    assign pkt_in_s = {opcode_s, cls_s, rdst2_s, rdst1_s, rsrc2_s, rsrc1_s,
                       src_addr_s, dst_addr_s, imm_s, ctl_s, illegal_s};

    decode_skid2 #(.W(PKT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (pkt_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (pkt_out_s)
    );

    assign {out_opcode, out_class, rdst2, rdst1, rsrc2, rsrc1,
            src_addr, dst_addr, imm, ctl, illegal} = pkt_out_s;

    // A flushed push never reaches the buffer, so it must not be counted.
    assign accept_s = in_valid && in_ready && !flush;

    // Saturating count of accepted illegal instructions; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (accept_s && illegal_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with default parameters.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] instr;
    logic [5:0]  out_opcode;
    logic [2:0]  out_class;
    logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
    logic [7:0]  src_addr, dst_addr, illegal_cnt;
    logic [15:0] imm;
    logic [6:0]  ctl;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];
    int          sent, recv;

    always #5 clk = ~clk;

    decode_stage #(
        .INSTR_W(32), .OPC_W(6), .REG_W(5), .ADDR_W(8), .IMM_W(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_class(out_class),
        .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2), .rsrc1(rsrc1),
        .src_addr(src_addr), .dst_addr(dst_addr), .imm(imm), .ctl(ctl),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 32'h0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cnt", 32'(illegal_cnt), 32'h0);
        chk("rst_imm", 32'(imm), 32'h0);
        chk("rst_ctl", 32'(ctl), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // per-class decode
        push1(32'h0060_1234);
        chk("ldi_valid", 32'(out_valid), 32'h1);
        chk("ldi_class", 32'(out_class), 32'h0);
        chk("ldi_rdst2", 32'(rdst2), 32'h3);
        chk("ldi_imm", 32'(imm), 32'h1234);
        chk("ldi_ctl", 32'(ctl), 32'h44);
        chk("ldi_rsrc1", 32'(rsrc1), 32'h0);
        chk("ldi_dst_addr", 32'(dst_addr), 32'h0);
        chk("ldi_illegal", 32'(illegal), 32'h0);

        push1(32'h1422_0064);
        chk("alu_class", 32'(out_class), 32'h4);
        chk("alu_opcode", 32'(out_opcode), 32'h5);
        chk("alu_regs", {12'h0, rdst2, rdst1, rsrc2, rsrc1}, {12'h0, 5'd1, 5'd2, 5'd3, 5'd4});
        chk("alu_ctl", 32'(ctl), 32'h78);
        chk("alu_imm", 32'(imm), 32'h0);

        push1(32'h0E94_00E0);
        chk("st_class", 32'(out_class), 32'h3);
        chk("st_dst_addr", 32'(dst_addr), 32'hA5);
        chk("st_rsrc2", 32'(rsrc2), 32'h7);
        chk("st_ctl", 32'(ctl), 32'h11);
        chk("st_rdst2", 32'(rdst2), 32'h0);
        chk("st_src_addr", 32'(src_addr), 32'h0);

        push1(32'h08A0_003C);
        chk("ld_class", 32'(out_class), 32'h2);
        chk("ld_rdst2", 32'(rdst2), 32'h5);
        chk("ld_src_addr", 32'(src_addr), 32'h3C);
        chk("ld_ctl", 32'(ctl), 32'h42);
        chk("ld_rsrc2", 32'(rsrc2), 32'h0);

        // illegal opcodes
        push1(32'hFC00_0000);
        chk("ill_class", 32'(out_class), 32'h7);
        chk("ill_flag", 32'(illegal), 32'h1);
        chk("ill_ctl", 32'(ctl), 32'h0);
        chk("ill_opcode", 32'(out_opcode), 32'h3F);
        chk("ill_cnt1", 32'(illegal_cnt), 32'h1);
        push1(32'h4422_0064);
        chk("ill17_flag", 32'(illegal), 32'h1);
        chk("ill17_rdst2", 32'(rdst2), 32'h0);
        chk("ill17_rsrc1", 32'(rsrc1), 32'h0);
        chk("ill_cnt2", 32'(illegal_cnt), 32'h2);
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // backpressure
        out_ready = 1'b0;
        push1(32'h0060_1111);
        chk("bp_ready_one", 32'(in_ready), 32'h1);
        push1(32'h0040_2222);
        chk("bp_ready_full", 32'(in_ready), 32'h0);
        chk("bp_head_a", 32'(imm), 32'h1111);
        tick();
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_a", 32'(imm), 32'h1111);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", 32'(imm), 32'h2222);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h0);

        // streaming at full rate
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            instr    = {16'h0060, 16'h0100 + 16'(i)};
            tick();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_imm", 32'(imm), 32'h100 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", 32'(out_valid), 32'h0);

        // random consumer stalls, order checked against a queue
        sent = 0;
        recv = 0;
        for (int c = 0; c < 400 && recv < 30; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 30) begin
                in_valid = 1'b1;
                instr    = {16'h0060, 16'h0200 + 16'(sent)};
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("rand_order", 32'(imm), 32'(exp_q.pop_front()));
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(16'h0200 + 16'(sent));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("rand_count", 32'(recv), 32'd30);
        out_ready = 1'b1;
        tick();

        // flush in FULL with a simultaneous push
        out_ready = 1'b0;
        push1(32'h0060_3333);
        push1(32'h0060_4444);
        chk("fl_full", 32'(in_ready), 32'h0);
        flush = 1'b1; in_valid = 1'b1; instr = 32'hFC00_0000;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_ready", 32'(in_ready), 32'h1);
        chk("fl_cnt", 32'(illegal_cnt), 32'h2);
        // flush in ONE with an illegal push that is ready to be taken
        push1(32'h0060_5555);
        flush = 1'b1; in_valid = 1'b1; instr = 32'hFC00_0000;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", 32'(out_valid), 32'h0);
        chk("fl1_cnt", 32'(illegal_cnt), 32'h2);
        out_ready = 1'b1;
        tick();
        chk("fl_no_ghost", 32'(out_valid), 32'h0);

        // 300 illegal pushes: 2 + 252 = 254, then saturate at 255
        in_valid = 1'b1; instr = 32'hFC00_0000;
        repeat (252) tick();
        chk("sat_254", 32'(illegal_cnt), 32'd254);
        repeat (48) tick();
        chk("sat_255", 32'(illegal_cnt), 32'd255);
        in_valid = 1'b0;
        tick();

        // asynchronous reset between edges with a full buffer
        out_ready = 1'b0;
        push1(32'h0060_6666);
        push1(32'h0060_7777);
        chk("ar_full", 32'(in_ready), 32'h0);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_ready", 32'(in_ready), 32'h1);
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_imm", 32'(imm), 32'h0);
        chk("ar_rdst2", 32'(rdst2), 32'h0);
        chk("ar_class", 32'(out_class), 32'h0);
        chk("ar_illegal", 32'(illegal), 32'h0);
        chk("ar_cnt", 32'(illegal_cnt), 32'h0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        push1(32'h1422_0064);
        chk("resume_valid", 32'(out_valid), 32'h1);
        chk("resume_rsrc1", 32'(rsrc1), 32'h4);
        chk("resume_class", 32'(out_class), 32'h4);
        tick();
        chk("resume_end", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
